if_fetch_unit: RTL and testbench

Instruction-fetch front end of the ARM 5-stage pipeline. It sits directly upstream of the IF/ID pipeline register and owns the program counter. It issues requests on a variable-latency instruction-memory request/acknowledge interface and buffers one returned instruction. It presents {PC+4, instruction} to the IF/ID register and redirects on taken branches from EX. It honours the pipeline freeze from the hazard unit.

---
 rtl/if_fetch_unit.sv | 213 +++++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch front end of the 5-stage ARM pipeline. Owns the program
// counter, issues one request at a time on a variable-latency instruction
// memory request/acknowledge interface, and keeps a single-entry buffer of
// {instruction, PC+4} for the IF/ID pipeline register. Taken branches from EX
// redirect the PC and flush the buffer. The hazard unit's freeze holds the
// buffer and suppresses new requests while the buffer is occupied.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   freeze         downstream does not consume the buffer this cycle
//   branch_taken   one-cycle redirect pulse from EX
//   branch_addr    redirect target, valid with branch_taken
//   imem_req       fetch request (registered)
//   imem_addr      fetch address, stable while imem_req=1
//   imem_ack       one-cycle response strobe, data valid the same cycle
//   imem_rdata     returned instruction word
//   instr_valid    buffer holds a valid instruction
//   instr_out      buffered instruction, 0 (NOP) when invalid
//   pc_out         fetch address + PC_INC of the buffered instruction, 0 when invalid
//
// Optional feature (macro IF_FETCH_PERF_EN):
//   perf_fetches     accepted, non-discarded acks
//   perf_wait_cycles cycles spent waiting for an ack (REQ or DROP, no ack)
//   perf_discards    acks thrown away because of a redirect
//   All counters saturate at all-ones and ignore freeze.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_wait_cycles,
  output logic [15:0] perf_discards
`endif
);

  // IDLE: nothing outstanding; REQ: result will be kept; DROP: result discarded
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic        buf_free;

  // The buffer can accept a new instruction next cycle if it is empty now or
  // is being consumed this cycle.
  assign buf_free = !buf_valid_q || !freeze;

  // Next-state, PC and buffer update. Consumption (freeze=0) empties the
  // buffer by default; a load or a branch flush then overrides that.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;

    if (!freeze) begin
      buf_valid_d = 1'b0;
      buf_instr_d = 32'h0;
      buf_pc4_d   = 32'h0;
    end

    case (state_q)
      IDLE: begin
        if (branch_taken) begin
          // Redirect first; the request to the target goes out next cycle.
          pc_d        = branch_addr;
          buf_valid_d = 1'b0;
          buf_instr_d = 32'h0;
          buf_pc4_d   = 32'h0;
        end else if (buf_free) begin
          state_d    = REQ;
          req_addr_d = pc_q;
          pc_d       = pc_q + PC_INC;
        end
      end

      REQ: begin
        if (branch_taken) begin
          // Flush even when frozen; an in-flight response must be discarded.
          pc_d        = branch_addr;
          buf_valid_d = 1'b0;
          buf_instr_d = 32'h0;
          buf_pc4_d   = 32'h0;
          state_d     = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          buf_valid_d = 1'b1;
          buf_instr_d = imem_rdata;
          buf_pc4_d   = req_addr_q + PC_INC;
          // The freshly loaded entry is valid, so another fetch is only safe
          // if the consumer is not frozen.
          if (!freeze) begin
            state_d    = REQ;
            req_addr_d = pc_q;
            pc_d       = pc_q + PC_INC;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DROP: begin
        // The old request stays on the bus until it is acknowledged.
        if (branch_taken) begin
          pc_d = branch_addr;
        end
        if (imem_ack) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, PC, request address and output buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= 32'h0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= 32'h0;
      buf_pc4_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
    end
  end

  assign imem_req    = (state_q != IDLE);
  assign imem_addr   = req_addr_q;
  assign instr_valid = buf_valid_q;
  assign instr_out   = buf_instr_q;
  assign pc_out      = buf_pc4_q;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetches_q, perf_fetches_d;
  logic [31:0] perf_wait_cycles_q, perf_wait_cycles_d;
  logic [15:0] perf_discards_q, perf_discards_d;
  logic        fetch_inc, wait_inc, discard_inc;

  assign fetch_inc   = (state_q == REQ) && imem_ack && !branch_taken;
  assign wait_inc    = (state_q != IDLE) && !imem_ack;
  assign discard_inc = imem_ack && (((state_q == REQ) && branch_taken) || (state_q == DROP));

  // Saturating increments.
  always_comb begin
    perf_fetches_d     = perf_fetches_q;
    perf_wait_cycles_d = perf_wait_cycles_q;
    perf_discards_d    = perf_discards_q;
    if (fetch_inc && (perf_fetches_q != 32'hFFFF_FFFF)) begin
      perf_fetches_d = perf_fetches_q + 32'd1;
    end
    if (wait_inc && (perf_wait_cycles_q != 32'hFFFF_FFFF)) begin
      perf_wait_cycles_d = perf_wait_cycles_q + 32'd1;
    end
    if (discard_inc && (perf_discards_q != 16'hFFFF)) begin
      perf_discards_d = perf_discards_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetches_q     <= 32'h0;
      perf_wait_cycles_q <= 32'h0;
      perf_discards_q    <= 16'h0;
    end else begin
      perf_fetches_q     <= perf_fetches_d;
      perf_wait_cycles_q <= perf_wait_cycles_d;
      perf_discards_q    <= perf_discards_d;
    end
  end

  assign perf_fetches     = perf_fetches_q;
  assign perf_wait_cycles = perf_wait_cycles_q;
  assign perf_discards    = perf_discards_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Self-checking bench for if_fetch_unit. A transaction-level reference model
// (outstanding-request flags, a queue for the output buffer, plain counters)
// predicts every output after each clock edge. Directed scenarios are followed
// by a randomized phase with random freeze, redirects, memory latency and
// stale acks. A second instance with RESET_PC=32'hFFFF_FFFC covers PC wrap.
// Perf counter checks are compiled in when IF_FETCH_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_imem_ack;
  logic [31:0] w_imem_rdata;
  logic        w_instr_valid;
  logic [31:0] w_instr_out;
  logic [31:0] w_pc_out;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetches;
  logic [31:0] perf_wait_cycles;
  logic [15:0] perf_discards;
  logic [31:0] w_perf_fetches;
  logic [31:0] w_perf_wait_cycles;
  logic [15:0] w_perf_discards;
`endif

  if_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_out    (instr_out),
    .pc_out       (pc_out)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetches     (perf_fetches),
    .perf_wait_cycles (perf_wait_cycles),
    .perf_discards    (perf_discards)
`endif
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_INC(32'd4)) u_wrap (
    .clk          (clk),
    .reset        (reset),
    .freeze       (1'b0),
    .branch_taken (1'b0),
    .branch_addr  (32'h0),
    .imem_req     (w_imem_req),
    .imem_addr    (w_imem_addr),
    .imem_ack     (w_imem_ack),
    .imem_rdata   (w_imem_rdata),
    .instr_valid  (w_instr_valid),
    .instr_out    (w_instr_out),
    .pc_out       (w_pc_out)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetches     (w_perf_fetches),
    .perf_wait_cycles (w_perf_wait_cycles),
    .perf_discards    (w_perf_discards)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  entry_t      bufq[$];
  bit          m_busy;
  bit          m_drop;
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  int          m_fetches;
  int          m_waits;
  int          m_discards;
  int          wait_left;
  int          lat_cfg;
  bit          stale_en;

  int checks;
  int errors;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    bufq.delete();
    m_busy     = 1'b0;
    m_drop     = 1'b0;
    m_pc       = 32'h0;
    m_addr     = 32'h0;
    m_fetches  = 0;
    m_waits    = 0;
    m_discards = 0;
    wait_left  = 0;
  endtask

  task automatic modelIssue();
    m_busy    = 1'b1;
    m_drop    = 1'b0;
    m_addr    = m_pc;
    m_pc      = m_pc + 32'd4;
    wait_left = lat_cfg;
  endtask

  // One clock edge of the fetch unit's rules, expressed as transactions.
  task automatic modelUpdate(input bit f, input bit br, input logic [31:0] ba,
                             input bit ack, input logic [31:0] rd);
    bit free;
    entry_t e;
    free = (bufq.size() == 0) || !f;
    if (!f) bufq.delete();
    if (m_busy && !ack) m_waits++;
    if (!m_busy) begin
      if (br) begin
        m_pc = ba;
        bufq.delete();
      end else if (free) begin
        modelIssue();
      end
    end else if (m_drop) begin
      if (br) m_pc = ba;
      if (ack) begin
        m_busy = 1'b0;
        m_discards++;
      end
    end else if (br) begin
      bufq.delete();
      m_pc = ba;
      if (ack) begin
        m_busy = 1'b0;
        m_discards++;
      end else begin
        m_drop = 1'b1;
      end
    end else if (ack) begin
      bufq.delete();
      e.instr = rd;
      e.pc4   = m_addr + 32'd4;
      bufq.push_back(e);
      m_fetches++;
      if (!f) modelIssue();
      else m_busy = 1'b0;
    end
  endtask

  task automatic checkOutput();
    checkEq("imem_req", {31'h0, imem_req}, {31'h0, m_busy});
    if (m_busy) checkEq("imem_addr", imem_addr, m_addr);
    checkEq("instr_valid", {31'h0, instr_valid}, {31'h0, (bufq.size() != 0)});
    checkEq("instr_out", instr_out, (bufq.size() != 0) ? bufq[0].instr : 32'h0);
    checkEq("pc_out", pc_out, (bufq.size() != 0) ? bufq[0].pc4 : 32'h0);
`ifdef IF_FETCH_PERF_EN
    checkEq("perf_fetches", perf_fetches, m_fetches);
    checkEq("perf_wait_cycles", perf_wait_cycles, m_waits);
    checkEq("perf_discards", {16'h0, perf_discards}, {16'h0, m_discards[15:0]});
`endif
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check after it.
  task automatic applyStimulus(input bit f, input bit br, input logic [31:0] ba,
                               input bit ack, input logic [31:0] rd);
    freeze       = f;
    branch_taken = br;
    branch_addr  = ba;
    imem_ack     = ack;
    imem_rdata   = rd;
    @(posedge clk);
    modelUpdate(f, br, ba, ack, rd);
    #1;
    checkOutput();
  endtask

  // Memory model: ack after the configured latency; optional stale acks in idle.
  task automatic autoCycle(input bit f, input bit br, input logic [31:0] ba,
                           input logic [31:0] rd);
    bit ack;
    ack = 1'b0;
    if (m_busy) begin
      if (wait_left == 0) ack = 1'b1;
      else wait_left--;
    end else if (stale_en) begin
      ack = ($urandom_range(0, 7) == 0);
    end
    applyStimulus(f, br, ba, ack, rd);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    imem_ack     = 1'b0;
    imem_rdata   = 32'h0;
    w_imem_ack   = 1'b0;
    w_imem_rdata = 32'h0;
    stale_en     = 1'b0;
    lat_cfg      = 1;
    modelReset();

    // Reset state
    #1;
    checkOutput();
    checkEq("reset_imem_addr", imem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Sequential fetches, ack one cycle after each request
    autoCycle(1'b0, 1'b0, 32'h0, $urandom);
    checkEq("seq_addr0", imem_addr, 32'h0);
    for (int k = 0; k < 2; k++) begin
      autoCycle(1'b0, 1'b0, 32'h0, $urandom);
      autoCycle(1'b0, 1'b0, 32'h0, $urandom);
      checkEq("seq_addr", imem_addr, 32'd4 * (k + 1));
      checkEq("seq_pc_out", pc_out, 32'd4 * (k + 1));
    end

    // Reset while the request to 8 is outstanding, then a stale ack in idle
    #3;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput();
    checkEq("midreset_req", {31'h0, imem_req}, 32'h0);
    checkEq("midreset_addr", imem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    checkEq("stale_ack_valid", {31'h0, instr_valid}, 32'h0);
    checkEq("restart_addr", imem_addr, 32'h0);

    // Freeze while the instruction from 0x10 comes back
    for (int i = 0; i < 40 && !(m_busy && m_addr == 32'h10); i++)
      autoCycle(1'b0, 1'b0, 32'h0, $urandom);
    for (int i = 0; i < 10 && m_busy; i++)
      autoCycle(1'b1, 1'b0, 32'h0, 32'hE3A0_1005);
    for (int i = 0; i < 3; i++) begin
      autoCycle(1'b1, 1'b0, 32'h0, $urandom);
      checkEq("frz_instr", instr_out, 32'hE3A0_1005);
      checkEq("frz_pc_out", pc_out, 32'h14);
      checkEq("frz_no_req", {31'h0, imem_req}, 32'h0);
    end
    autoCycle(1'b0, 1'b0, 32'h0, $urandom);
    checkEq("unfrz_addr", imem_addr, 32'h14);

    // Redirect while the request to 0x20 waits three cycles for its ack
    lat_cfg = 3;
    for (int i = 0; i < 60 && !(m_busy && m_addr == 32'h20); i++)
      autoCycle(1'b0, 1'b0, 32'h0, $urandom);
    autoCycle(1'b0, 1'b1, 32'h100, $urandom);
    for (int i = 0; i < 10 && m_busy; i++) begin
      autoCycle(1'b0, 1'b0, 32'h0, $urandom);
      if (imem_req) checkEq("drop_addr_held", imem_addr, 32'h20);
      checkEq("drop_valid", {31'h0, instr_valid}, 32'h0);
    end
    autoCycle(1'b0, 1'b0, 32'h0, $urandom);
    checkEq("redirect_addr", imem_addr, 32'h100);
    for (int i = 0; i < 10 && bufq.size() == 0; i++)
      autoCycle(1'b0, 1'b0, 32'h0, $urandom);
    checkEq("redirect_pc_out", pc_out, 32'h104);

    // Redirect coincident with ack while frozen with a full buffer
    lat_cfg = 2;
    for (int i = 0; i < 40 && !(m_busy && bufq.size() != 0); i++)
      autoCycle(1'b0, 1'b0, 32'h0, $urandom);
    for (int i = 0; i < 10 && wait_left != 0; i++)
      autoCycle(1'b1, 1'b0, 32'h0, $urandom);
    checkEq("full_before_br", {31'h0, instr_valid}, 32'h1);
    autoCycle(1'b1, 1'b1, 32'h200, $urandom);
    checkEq("br_ack_valid", {31'h0, instr_valid}, 32'h0);
    checkEq("br_ack_instr", instr_out, 32'h0);
    autoCycle(1'b1, 1'b0, 32'h0, $urandom);
    checkEq("br_ack_next_addr", imem_addr, 32'h200);
    checkEq("br_ack_next_req", {31'h0, imem_req}, 32'h1);

    // Randomized traffic
    stale_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      lat_cfg = $urandom_range(1, 4);
      autoCycle(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0),
                ($urandom & 32'hFFFF_FFFC), $urandom);
    end
    stale_en = 1'b0;

    // PC wrap on the instance that starts at 32'hFFFF_FFFC
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkEq("wrap_first_addr", w_imem_addr, 32'hFFFF_FFFC);
    checkEq("wrap_first_req", {31'h0, w_imem_req}, 32'h1);
    w_imem_ack   = 1'b1;
    w_imem_rdata = 32'hE1A0_0000;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    w_imem_ack   = 1'b0;
    checkEq("wrap_pc_out", w_pc_out, 32'h0);
    checkEq("wrap_valid", {31'h0, w_instr_valid}, 32'h1);
    checkEq("wrap_instr", w_instr_out, 32'hE1A0_0000);
    checkEq("wrap_second_addr", w_imem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
